// File: rtl/spi_host_flash_rd_seq.sv
// Flash read sequencer: turns one read request into SPI host TX words
// and a chained TX / dummy / RX command segment stream.
module spi_host_flash_rd_seq #(
  parameter int NumCS       = 1,
  parameter int MaxSegBytes = 512,
  localparam int CSW = (NumCS > 1) ? $clog2(NumCS) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           sw_rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [7:0]     req_opcode_i,
  input  logic [31:0]    req_addr_i,
  input  logic           req_addr4b_i,
  input  logic [3:0]     req_dummy_i,
  input  logic [11:0]    req_len_i,
  input  logic [CSW-1:0] req_csid_i,
  output logic           cmd_valid_o,
  input  logic           cmd_ready_i,
  output logic [8:0]     cmd_len_o,
  output logic           cmd_csaat_o,
  output logic [1:0]     cmd_dir_o,
  output logic [1:0]     cmd_speed_o,
  output logic [CSW-1:0] cmd_csid_o,
  output logic [31:0]    tx_data_o,
  output logic [3:0]     tx_be_o,
  output logic           tx_valid_o,
  input  logic           tx_ready_i,
  output logic           busy_o,
  output logic           done_o
);

  typedef enum logic [2:0] {
    IDLE,
    TX0,
    TX1,
    CMD_TX,
    CMD_DUMMY,
    CMD_RX,
    DONE
  } state_e;

  localparam logic [12:0] MaxSeg = 13'(MaxSegBytes);

  state_e           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic             a4_q, a4_d;
  logic [3:0]       dummy_q, dummy_d;
  logic [CSW-1:0]   csid_q, csid_d;
  logic [12:0]      rem_q, rem_d;
  logic             done_q, done_d;
  logic [12:0]      seg;
  logic             last_seg;

  assign last_seg    = (rem_q <= MaxSeg);
  assign seg         = last_seg ? rem_q : MaxSeg;
  assign cmd_speed_o = 2'b00;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);
  assign cmd_csid_o  = busy_o ? csid_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || sw_rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      a4_q    <= 1'b0;
      dummy_q <= '0;
      csid_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      a4_q    <= a4_d;
      dummy_q <= dummy_d;
      csid_q  <= csid_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    a4_d        = a4_q;
    dummy_d     = dummy_q;
    csid_d      = csid_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    req_ready_o = 1'b0;
    cmd_valid_o = 1'b0;
    cmd_len_o   = '0;
    cmd_csaat_o = 1'b0;
    cmd_dir_o   = 2'd0;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    tx_be_o     = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          op_d    = req_opcode_i;
          addr_d  = req_addr_i;
          a4_d    = req_addr4b_i;
          dummy_d = req_dummy_i;
          csid_d  = req_csid_i;
          rem_d   = 13'(req_len_i) + 13'd1;
          state_d = TX0;
        end
      end
      TX0: begin
        tx_valid_o = 1'b1;
        tx_be_o    = 4'hF;
        // Opcode goes out first, then the address MSB first.
        tx_data_o  = a4_q
          ? {addr_q[15:8], addr_q[23:16], addr_q[31:24], op_q}
          : {addr_q[7:0], addr_q[15:8], addr_q[23:16], op_q};
        if (tx_ready_i) begin
          state_d = a4_q ? TX1 : CMD_TX;
        end
      end
      TX1: begin
        tx_valid_o = 1'b1;
        tx_be_o    = 4'b0001;
        tx_data_o  = {24'h0, addr_q[7:0]};
        if (tx_ready_i) begin
          state_d = CMD_TX;
        end
      end
      CMD_TX: begin
        cmd_valid_o = 1'b1;
        cmd_dir_o   = 2'd2;
        cmd_len_o   = a4_q ? 9'd4 : 9'd3;
        cmd_csaat_o = 1'b1;
        if (cmd_ready_i) begin
          state_d = (dummy_q != 4'd0) ? CMD_DUMMY : CMD_RX;
        end
      end
      CMD_DUMMY: begin
        cmd_valid_o = 1'b1;
        cmd_dir_o   = 2'd0;
        cmd_len_o   = {5'd0, dummy_q - 4'd1};
        cmd_csaat_o = 1'b1;
        if (cmd_ready_i) begin
          state_d = CMD_RX;
        end
      end
      CMD_RX: begin
        cmd_valid_o = 1'b1;
        cmd_dir_o   = 2'd1;
        cmd_len_o   = 9'(seg - 13'd1);
        cmd_csaat_o = !last_seg;
        if (cmd_ready_i) begin
          rem_d = rem_q - seg;
          if (last_seg) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_host_flash_rd_seq.sv
// Randomised bench for spi_host_flash_rd_seq: a byte-stream / segment
// model predicts TX words and command segments, checked every cycle.
module tb_spi_host_flash_rd_seq;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  be;
  } tx_t;

  typedef struct packed {
    logic [1:0] dir;
    logic [8:0] len;
    logic       csaat;
    logic       csid;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sw_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [7:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic        req_a4 = 1'b0;
  logic [3:0]  req_dummy = '0;
  logic [11:0] req_len = '0;
  logic [0:0]  req_csid = '0;
  logic        cmd_valid_o;
  logic        cmd_ready = 1'b0;
  logic [8:0]  cmd_len_o;
  logic        cmd_csaat_o;
  logic [1:0]  cmd_dir_o;
  logic [1:0]  cmd_speed_o;
  logic [0:0]  cmd_csid_o;
  logic [31:0] tx_data_o;
  logic [3:0]  tx_be_o;
  logic        tx_valid_o;
  logic        tx_ready = 1'b0;
  logic        busy_o;
  logic        done_o;

  spi_host_flash_rd_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .sw_rst_i     (sw_rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_opcode_i (req_op),
    .req_addr_i   (req_addr),
    .req_addr4b_i (req_a4),
    .req_dummy_i  (req_dummy),
    .req_len_i    (req_len),
    .req_csid_i   (req_csid),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready),
    .cmd_len_o    (cmd_len_o),
    .cmd_csaat_o  (cmd_csaat_o),
    .cmd_dir_o    (cmd_dir_o),
    .cmd_speed_o  (cmd_speed_o),
    .cmd_csid_o   (cmd_csid_o),
    .tx_data_o    (tx_data_o),
    .tx_be_o      (tx_be_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  int   n_done = 0;
  int   exp_dones = 0;
  bit   stall = 0;
  bit   hold_rx = 0;
  tx_t  tx_q[$];
  cmd_t cmd_q[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Request serialised as a byte stream: opcode, then address MSB first,
  // packed four bytes per word with the first byte in the low lane.
  function automatic tx_t model_tx(input logic [7:0] op,
                                   input logic [31:0] a,
                                   input logic a4, input int w);
    logic [7:0] b[8];
    int n;
    tx_t t;
    n = a4 ? 5 : 4;
    b[0] = op;
    for (int i = 0; i < n - 1; i++) b[i+1] = 8'(a >> (8 * (n - 2 - i)));
    t = '0;
    for (int k = 0; k < 4; k++) begin
      if (4 * w + k < n) begin
        t.d[8*k +: 8] = b[4*w+k];
        t.be[k] = 1'b1;
      end
    end
    return t;
  endfunction

  function automatic int rx_count(input int len);
    return (len + 1 + 511) / 512;
  endfunction

  function automatic cmd_t rx_cmd(input int len, input int k,
                                  input logic cs);
    int rem, s;
    cmd_t c;
    rem = len + 1 - 512 * k;
    s = (rem > 512) ? 512 : rem;
    c.dir = 2'd1;
    c.len = 9'(s - 1);
    c.csaat = (rem > 512);
    c.csid = cs;
    return c;
  endfunction

  task automatic push_model(input logic [7:0] op, input logic [31:0] a,
                            input logic a4, input logic [3:0] dm,
                            input int len, input logic cs);
    cmd_t c;
    for (int w = 0; w < (a4 ? 2 : 1); w++) tx_q.push_back(model_tx(op, a, a4, w));
    c.dir = 2'd2;
    c.len = a4 ? 9'd4 : 9'd3;
    c.csaat = 1'b1;
    c.csid = cs;
    cmd_q.push_back(c);
    if (dm != 0) begin
      c.dir = 2'd0;
      c.len = 9'(int'(dm) - 1);
      cmd_q.push_back(c);
    end
    for (int k = 0; k < rx_count(len); k++) cmd_q.push_back(rx_cmd(len, k, cs));
  endtask

  always @(posedge clk) begin
    #1;
    tx_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (hold_rx) cmd_ready = !(cmd_valid_o && cmd_dir_o == 2'd1);
    else cmd_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  bit   was_rst = 1;
  bit   exp_done = 0;
  bit   prev_tv = 0, prev_tr = 0, prev_cv = 0, prev_cr = 0, prev_done = 0;
  tx_t  prev_tx;
  cmd_t prev_cmd;

  always @(negedge clk) begin
    tx_t  et, at;
    cmd_t ec, ac;
    at = '{d: tx_data_o, be: tx_be_o};
    ac = '{dir: cmd_dir_o, len: cmd_len_o, csaat: cmd_csaat_o,
           csid: cmd_csid_o};
    if (!rst_ni || sw_rst) begin
      tx_q.delete();
      cmd_q.delete();
      was_rst = 1;
      exp_done = 0;
      prev_tv = 0;
      prev_cv = 0;
      prev_done = 0;
    end else begin
      if (was_rst) begin
        chk("idle_ready", req_ready_o, 1);
        chk("idle_busy", busy_o, 0);
        chk("idle_valids", {cmd_valid_o, tx_valid_o, done_o}, 0);
        chk("idle_data", {tx_data_o, tx_be_o, cmd_len_o}, 0);
        was_rst = 0;
      end
      chk("done", done_o, exp_done);
      exp_done = 0;
      if (done_o) n_done++;
      chk("ready_vs_busy", req_ready_o, !busy_o);
      chk("valid_excl", cmd_valid_o && tx_valid_o, 0);
      if (prev_done) chk("idle_after_done", busy_o, 0);
      if (prev_tv && !prev_tr) begin
        chk("tx_hold_valid", tx_valid_o, 1);
        chk("tx_hold_data", at, prev_tx);
      end
      if (prev_cv && !prev_cr) begin
        chk("cmd_hold_valid", cmd_valid_o, 1);
        chk("cmd_hold_data", ac, prev_cmd);
      end
      if (tx_valid_o && tx_ready) begin
        if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          et = tx_q.pop_front();
          chk("tx_word", at, et);
        end
      end
      if (cmd_valid_o && cmd_ready) begin
        chk("cmd_speed", cmd_speed_o, 0);
        if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
        else begin
          ec = cmd_q.pop_front();
          chk("cmd_seg", ac, ec);
          exp_done = !ec.csaat;
        end
      end
      prev_tv = tx_valid_o;
      prev_tr = tx_ready;
      prev_cv = cmd_valid_o;
      prev_cr = cmd_ready;
      prev_tx = at;
      prev_cmd = ac;
      prev_done = done_o;
    end
  end

  task automatic issue(input logic [7:0] op, input logic [31:0] a,
                       input logic a4, input logic [3:0] dm,
                       input logic [11:0] len, input logic cs,
                       input bit keep);
    bit acc;
    @(posedge clk);
    #1;
    req_op = op;
    req_addr = a;
    req_a4 = a4;
    req_dummy = dm;
    req_len = len;
    req_csid = cs;
    req_valid = 1'b1;
    push_model(op, a, a4, dm, int'(len), cs);
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        acc = 1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    exp_dones++;
  endtask

  task automatic run(input logic [7:0] op, input logic [31:0] a,
                     input logic a4, input logic [3:0] dm,
                     input logic [11:0] len);
    issue(op, a, a4, dm, len, 1'($urandom_range(0, 1)), 0);
    wait_done();
  endtask

  initial begin
    tx_t  t;
    cmd_t c;
    bit   got;

    t = model_tx(8'h03, 32'h0012_3456, 1'b0, 0);
    chk("model_tx3", t, {32'h5634_1203, 4'hF});
    t = model_tx(8'h0C, 32'hAABB_CCDD, 1'b1, 0);
    chk("model_tx4_w0", t, {32'hCCBB_AA0C, 4'hF});
    t = model_tx(8'h0C, 32'hAABB_CCDD, 1'b1, 1);
    chk("model_tx4_w1", t, {32'h0000_00DD, 4'h1});
    chk("model_nseg_4096", rx_count(4095), 8);
    c = rx_cmd(4095, 6, 1'b0);
    chk("model_seg7", {c.len, c.csaat}, {9'd511, 1'b1});
    c = rx_cmd(599, 1, 1'b0);
    chk("model_seg600_last", {c.len, c.csaat}, {9'd87, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);

    run(8'h03, 32'h0012_3456, 1'b0, 4'd0, 12'd15);
    run(8'h0C, 32'hAABB_CCDD, 1'b1, 4'd8, 12'd3);
    run(8'h0B, 32'h00FF_0000, 1'b0, 4'd1, 12'd4095);
    run(8'h03, 32'h0000_0010, 1'b0, 4'd0, 12'd599);
    run(8'h13, 32'h8000_0001, 1'b1, 4'd15, 12'd511);
    run(8'h03, 32'h0000_0000, 1'b0, 4'd0, 12'd0);

    stall = 1;
    run(8'h0C, 32'hAABB_CCDD, 1'b1, 4'd8, 12'd3);
    run(8'h0B, 32'h0012_3456, 1'b0, 4'd2, 12'd4095);
    for (int n = 0; n < 40; n++) begin
      run(8'($urandom), $urandom, 1'($urandom_range(0, 1)),
          4'($urandom), 12'($urandom));
    end
    stall = 0;

    hold_rx = 1;
    issue(8'h03, 32'h0000_1000, 1'b0, 4'd0, 12'd999, 1'b1, 0);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_valid_o && cmd_dir_o == 2'd1) begin
        got = 1;
        break;
      end
    end
    chk("rx_reached", got, 1);
    chk("rx_first_seg", {cmd_len_o, cmd_csaat_o}, {9'd511, 1'b1});
    @(posedge clk);
    #1;
    sw_rst = 1'b1;
    @(posedge clk);
    #1;
    sw_rst = 1'b0;
    hold_rx = 0;
    @(negedge clk);
    chk("swrst_valids", {cmd_valid_o, tx_valid_o}, 0);
    chk("swrst_ready", req_ready_o, 1);
    run(8'h3B, 32'h0055_AA00, 1'b0, 4'd4, 12'd700);

    issue(8'h03, 32'h0001_0203, 1'b0, 4'd0, 12'd31, 1'b0, 1);
    req_op = 8'h0C;
    req_addr = 32'h0405_0607;
    req_a4 = 1'b1;
    req_dummy = 4'd6;
    req_len = 12'd1023;
    req_csid = 1'b1;
    push_model(8'h0C, 32'h0405_0607, 1'b1, 4'd6, 1023, 1'b1);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1;
        break;
      end
      chk("b2b_busy", busy_o, 1);
    end
    chk("b2b_first_done", got, 1);
    exp_dones++;
    @(negedge clk);
    chk("b2b_gap", {busy_o, req_ready_o}, 2'b01);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_acc", busy_o, 1);
    wait_done();

    repeat (3) @(negedge clk);
    chk("done_count", n_done, exp_dones);
    chk("tx_q_drained", tx_q.size(), 0);
    chk("cmd_q_drained", cmd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
